// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and sizing defaults.
package uart_pkg;

  localparam int ACK_TIMEOUT_DEF = 4;
  localparam int NUM_REQ_MAX     = 8;

  typedef enum logic [1:0] {
    ARB       = 2'b00,
    LAUNCH    = 2'b01,
    WAIT_ACT  = 2'b10,
    WAIT_DONE = 2'b11
  } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping upward.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] pos_idx;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        idx = pos_idx;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, one byte in flight at a time.
// Define UART_TX_ARB_LOCK_EN to keep the grant on a requester until it sends a Last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic [IDX_W-1:0]     o_Grant_Idx,
  output logic                 o_Busy,
  output logic                 o_Err
);

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   to_cnt;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   next_ptr;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_bytes
    assign req_bytes[r] = i_Req_Data[8*r +: 8];
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic               lock_vld;
  logic [IDX_W-1:0]   lock_idx;
  logic [NUM_REQ-1:0] lock_mask;

  always_comb begin
    lock_mask = '1;
    if (lock_vld) begin
      lock_mask           = '0;
      lock_mask[lock_idx] = 1'b1;
    end
  end

  assign req_eff = i_Req_Valid & lock_mask;
`else
  logic unused_last;
  assign unused_last = ^i_Req_Last;
  assign req_eff     = i_Req_Valid;
`endif

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_eff),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign o_Busy   = (state != ARB);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ARB;
      ptr         <= '0;
      to_cnt      <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= '0;
      o_Req_Ready <= '0;
      o_Grant_Idx <= '0;
      o_Err       <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_vld    <= 1'b0;
      lock_idx    <= '0;
`endif
    end else begin
      o_TX_DV     <= 1'b0;
      o_Req_Ready <= '0;
      o_Err       <= 1'b0;
      case (state)
        ARB: begin
          if (pick_any && !i_TX_Active) begin
            state       <= LAUNCH;
            o_TX_DV     <= 1'b1;
            o_Req_Ready <= pick_grant;
            o_Grant_Idx <= pick_idx;
            o_TX_Byte   <= req_bytes[pick_idx];
`ifdef UART_TX_ARB_LOCK_EN
            // Pointer stays put while a packet holds the lock.
            if (i_Req_Last[pick_idx]) begin
              lock_vld <= 1'b0;
              ptr      <= next_ptr;
            end else begin
              lock_vld <= 1'b1;
              lock_idx <= pick_idx;
            end
`else
            ptr         <= next_ptr;
`endif
          end
        end
        LAUNCH: begin
          state  <= WAIT_ACT;
          to_cnt <= '0;
        end
        WAIT_ACT: begin
          // A Done seen before Active means the frame was short; treat it as complete.
          if (i_TX_Done) begin
            state <= ARB;
          end else if (i_TX_Active) begin
            state <= WAIT_DONE;
          end else if (to_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state <= ARB;
            o_Err <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            lock_vld <= 1'b0;
`endif
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_TX_Done) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a serial transmitter model and a round-robin reference.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int IDX_W        = 2;
  localparam int CLKS_PER_BIT = 4;
  localparam int MAX_ITEMS    = 16;

  logic                 i_Clock;
  logic                 i_Rst_L;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic [IDX_W-1:0]     o_Grant_Idx;
  logic                 o_Busy;
  logic                 o_Err;
  logic                 frc_active;

  // Transmitter model state
  logic       mdl_busy, mdl_active, mdl_done, mdl_serial, mdl_ignore;
  logic [9:0] mdl_frame;
  int         mdl_bit, mdl_clk;
  logic       serial_q[$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(4)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Req_Valid (req_valid),
    .i_Req_Data  (req_data),
    .i_Req_Last  (req_last),
    .o_Req_Ready (o_Req_Ready),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (mdl_active | frc_active),
    .i_TX_Done   (mdl_done),
    .o_Grant_Idx (o_Grant_Idx),
    .o_Busy      (o_Busy),
    .o_Err       (o_Err)
  );

  // ---------------- clock / reset ----------------
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;
  initial forever begin
    @(posedge i_Clock);
    cyc = cyc + 1;
  end

  // ---------------- requester store and reference ----------------
  logic [8:0]       rq_mem [NUM_REQ][MAX_ITEMS];
  int               rq_head [NUM_REQ];
  int               rq_tail [NUM_REQ];
  int               mdl_ptr;
  logic [IDX_W-1:0] exp_idx_q[$];
  logic [7:0]       exp_byte_q[$];
  logic [IDX_W-1:0] got_idx_q[$];
  logic [7:0]       got_byte_q[$];
  int               got_cyc_q[$];
  int               done_cyc_q[$];
  int               err_cyc_q[$];

  task automatic drive_req(input int r);
    if (rq_head[r] < rq_tail[r]) begin
      req_valid[r]      = 1'b1;
      req_data[8*r +: 8] = rq_mem[r][rq_head[r]][7:0];
      req_last[r]       = rq_mem[r][rq_head[r]][8];
    end else begin
      req_valid[r]      = 1'b0;
      req_data[8*r +: 8] = 8'h00;
      req_last[r]       = 1'b0;
    end
  endtask

  task automatic push_req(input int r, input logic [7:0] b, input logic last);
    rq_mem[r][rq_tail[r]] = {last, b};
    rq_tail[r] = rq_tail[r] + 1;
    drive_req(r);
  endtask

  task automatic clear_all();
    for (int r = 0; r < NUM_REQ; r++) begin
      rq_head[r] = 0;
      rq_tail[r] = 0;
      drive_req(r);
    end
    exp_idx_q.delete(); exp_byte_q.delete();
    got_idx_q.delete(); got_byte_q.delete(); got_cyc_q.delete();
    done_cyc_q.delete(); err_cyc_q.delete(); serial_q.delete();
  endtask

  // Reference: walk pending items in round-robin order from the model pointer.
  task automatic predict();
    int head [NUM_REQ];
    int left, ptr, lock, w;
    logic [8:0] item;
    left = 0; ptr = mdl_ptr; lock = -1;
    for (int r = 0; r < NUM_REQ; r++) begin
      head[r] = rq_head[r];
      left += rq_tail[r] - rq_head[r];
    end
    while (left > 0) begin
      w = -1;
      if (lock >= 0) w = lock;
      else begin
        for (int i = 0; i < NUM_REQ; i++)
          if (w < 0 && head[(ptr + i) % NUM_REQ] < rq_tail[(ptr + i) % NUM_REQ]) w = (ptr + i) % NUM_REQ;
      end
      item = rq_mem[w][head[w]];
      head[w]++;
      left--;
      exp_idx_q.push_back(IDX_W'(w));
      exp_byte_q.push_back(item[7:0]);
`ifdef UART_TX_ARB_LOCK_EN
      if (!item[8]) lock = w;
      else begin lock = -1; ptr = (w + 1) % NUM_REQ; end
`else
      ptr = (w + 1) % NUM_REQ;
`endif
    end
    mdl_ptr = ptr;
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    clear_all();
    repeat (3) @(negedge i_Clock);
    i_Rst_L = 1'b1;
    mdl_ptr = 0;
    clear_all();
  endtask

  task automatic wait_grants(input int n, output bit ok);
    int b = 0;
    while (got_idx_q.size() < n && b < 3000) begin
      @(negedge i_Clock); #1;
      b++;
    end
    ok = (got_idx_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int b = 0;
    @(negedge i_Clock); #1;
    while ((o_Busy || mdl_busy) && b < 300) begin
      @(negedge i_Clock); #1;
      b++;
    end
    ok = !(o_Busy || mdl_busy);
  endtask

  // ---------------- transmitter model ----------------
  initial begin
    mdl_busy = 0; mdl_active = 0; mdl_done = 0; mdl_serial = 1;
    mdl_frame = '0; mdl_bit = 0; mdl_clk = 0; mdl_ignore = 0;
    forever begin
      @(posedge i_Clock or negedge i_Rst_L);
      if (!i_Rst_L) begin
        mdl_busy <= 0; mdl_active <= 0; mdl_done <= 0; mdl_serial <= 1;
      end else begin
        mdl_done <= 1'b0;
        if (!mdl_busy) begin
          if (o_TX_DV && !mdl_ignore) begin
            mdl_busy   <= 1'b1;
            mdl_active <= 1'b1;
            mdl_frame  <= {1'b1, o_TX_Byte, 1'b0};
            mdl_bit    <= 0;
            mdl_clk    <= 0;
            mdl_serial <= 1'b0;
            serial_q.push_back(1'b0);
          end
        end else if (mdl_clk == CLKS_PER_BIT - 1) begin
          mdl_clk <= 0;
          if (mdl_bit == 9) begin
            mdl_busy <= 0; mdl_active <= 0; mdl_done <= 1'b1; mdl_serial <= 1'b1;
          end else begin
            mdl_bit    <= mdl_bit + 1;
            mdl_serial <= mdl_frame[mdl_bit + 1];
            serial_q.push_back(mdl_frame[mdl_bit + 1]);
          end
        end else begin
          mdl_clk <= mdl_clk + 1;
        end
      end
    end
  end

  // ---------------- monitor / requester responder ----------------
  initial begin
    logic prev_dv;
    int w;
    prev_dv = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (i_Rst_L) begin
        if (o_Req_Ready != '0 || o_TX_DV) begin
          num_checks++;
          if ($countones(o_Req_Ready) != 1 || !o_TX_DV) begin
            num_errors++;
            $display("FAIL handshake: ready=%b dv=%b, required one-hot ready with dv", o_Req_Ready, o_TX_DV);
          end
        end
        if (o_TX_DV) begin
          num_checks++;
          if (prev_dv) begin
            num_errors++;
            $display("FAIL dv_width: dv high for two cycles at cyc %0d, required one cycle", cyc);
          end
        end
        if (o_Req_Ready != '0) begin
          w = 0;
          for (int r = 0; r < NUM_REQ; r++) if (o_Req_Ready[r]) w = r;
          num_checks++;
          if (o_Grant_Idx !== IDX_W'(w)) begin
            num_errors++;
            $display("FAIL grant_idx: o_Grant_Idx=%0d, required %0d", o_Grant_Idx, w);
          end
          got_idx_q.push_back(IDX_W'(w));
          got_byte_q.push_back(o_TX_Byte);
          got_cyc_q.push_back(cyc);
          rq_head[w] = rq_head[w] + 1;
          drive_req(w);
        end
        if (mdl_done) done_cyc_q.push_back(cyc);
        if (o_Err) err_cyc_q.push_back(cyc);
        prev_dv = o_TX_DV;
      end else begin
        prev_dv = 1'b0;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    i_Rst_L = 1'b0;
    #1;
    num_checks += 6;
    if (o_TX_DV !== 1'b0)      begin num_errors++; $display("FAIL rst_dv: %b, required 0", o_TX_DV); end
    if (o_TX_Byte !== 8'h00)   begin num_errors++; $display("FAIL rst_byte: %h, required 00", o_TX_Byte); end
    if (o_Req_Ready !== '0)    begin num_errors++; $display("FAIL rst_ready: %b, required 0", o_Req_Ready); end
    if (o_Grant_Idx !== '0)    begin num_errors++; $display("FAIL rst_idx: %0d, required 0", o_Grant_Idx); end
    if (o_Busy !== 1'b0)       begin num_errors++; $display("FAIL rst_busy: %b, required 0", o_Busy); end
    if (o_Err !== 1'b0)        begin num_errors++; $display("FAIL rst_err: %b, required 0", o_Err); end
    do_reset();
  endtask

  task automatic test_single();
    int exp_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit ok;
    @(negedge i_Clock); #1;
    push_req(2, 8'hA5, 1'b1);
    predict();
    wait_grants(1, ok);
    num_checks++;
    if (!ok) begin num_errors++; $display("FAIL single_timeout: no grant, required 1"); end
    wait_idle(ok);
    num_checks += 5;
    if (!ok) begin num_errors++; $display("FAIL single_idle: still busy, required idle"); end
    if (got_idx_q.size() != 1 || got_idx_q[0] !== 2'd2 || got_byte_q[0] !== 8'hA5) begin
      num_errors++; $display("FAIL single_grant: %0d grants, required one grant of A5 to 2", got_idx_q.size());
    end
    if (o_TX_Byte !== 8'hA5) begin num_errors++; $display("FAIL single_byte_hold: %h, required a5", o_TX_Byte); end
    if (o_Grant_Idx !== 2'd2) begin num_errors++; $display("FAIL single_idx_hold: %0d, required 2", o_Grant_Idx); end
    if (serial_q.size() != 10) begin num_errors++; $display("FAIL single_frame_len: %0d bits, required 10", serial_q.size()); end
    for (int i = 0; i < 10 && i < serial_q.size(); i++) begin
      num_checks++;
      if (serial_q[i] !== exp_bits[i][0]) begin
        num_errors++; $display("FAIL single_frame_bit%0d: %b, required %0d", i, serial_q[i], exp_bits[i]);
      end
    end
    clear_all();
  endtask

  task automatic test_round_robin();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit ok;
    do_reset();
    @(negedge i_Clock); #1;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NUM_REQ; r++) push_req(r, 8'($urandom), 1'b1);
    predict();
    wait_grants(8, ok);
    num_checks++;
    if (!ok) begin num_errors++; $display("FAIL rr_timeout: %0d grants, required 8", got_idx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      num_checks++;
      if (i >= got_idx_q.size() || got_idx_q[i] !== IDX_W'(order[i]) || got_byte_q[i] !== exp_byte_q[i]) begin
        num_errors++; $display("FAIL rr_order%0d: grant mismatch, required idx %0d byte %h", i, order[i], exp_byte_q[i]);
      end
    end
    wait_idle(ok);
    clear_all();
  endtask

  task automatic test_active_hold();
    bit ok;
    int b;
    @(negedge i_Clock); #1;
    frc_active = 1'b1;
    push_req(1, 8'($urandom), 1'b1);
    predict();
    repeat (10) @(negedge i_Clock);
    #1;
    num_checks++;
    if (got_idx_q.size() != 0) begin num_errors++; $display("FAIL hold_active: %0d grants while active, required 0", got_idx_q.size()); end
    frc_active = 1'b0;
    wait_grants(1, ok);
    num_checks++;
    if (!ok || got_idx_q[0] !== 2'd1) begin num_errors++; $display("FAIL hold_release: no grant to 1 after release"); end
    wait_idle(ok);
    clear_all();
    // Second byte arrives while the first is on the wire.
    push_req(0, 8'($urandom), 1'b1);
    predict();
    b = 0;
    while (!mdl_active && b < 50) begin @(negedge i_Clock); #1; b++; end
    repeat (3) @(negedge i_Clock);
    #1;
    push_req(1, 8'($urandom), 1'b1);
    predict();
    wait_grants(2, ok);
    num_checks++;
    if (!ok || done_cyc_q.size() < 1) begin
      num_errors++; $display("FAIL hold_next: %0d grants %0d dones, required 2 and 1", got_idx_q.size(), done_cyc_q.size());
    end else if (got_cyc_q[1] - done_cyc_q[0] != 2) begin
      num_errors++; $display("FAIL hold_gap: launch %0d cycles after done, required 2", got_cyc_q[1] - done_cyc_q[0]);
    end
    wait_idle(ok);
    clear_all();
  endtask

  task automatic test_timeout();
    bit ok, seen;
    int b, gcyc;
    @(negedge i_Clock); #1;
    mdl_ignore = 1'b1;
    push_req(1, 8'h3C, 1'b1);
    predict();
    wait_grants(1, ok);
    gcyc = ok ? got_cyc_q[0] : 0;
    seen = 0; b = 0;
    while (!seen && b < 20) begin
      @(negedge i_Clock); #1;
      b++;
      if (o_Err) seen = 1;
    end
    num_checks += 3;
    if (!seen) begin num_errors++; $display("FAIL timeout_err: no err pulse, required one"); end
    else if (cyc - gcyc != 5) begin num_errors++; $display("FAIL timeout_delay: err %0d cycles after launch, required 5", cyc - gcyc); end
    if (o_Busy !== 1'b0) begin num_errors++; $display("FAIL timeout_state: busy=%b at err, required 0", o_Busy); end
    @(negedge i_Clock); #1;
    if (o_Err !== 1'b0) begin num_errors++; $display("FAIL timeout_pulse: err=%b, required 0", o_Err); end
    mdl_ignore = 1'b0;
    clear_all();
    push_req(2, 8'h5A, 1'b1);
    predict();
    wait_grants(1, ok);
    wait_idle(ok);
    num_checks++;
    if (!ok || got_idx_q.size() != 1 || got_idx_q[0] !== 2'd2 || err_cyc_q.size() != 0 || serial_q.size() != 10) begin
      num_errors++; $display("FAIL timeout_recover: %0d grants %0d errs, required 1 grant to 2 and 0 errs", got_idx_q.size(), err_cyc_q.size());
    end
    clear_all();
  endtask

  task automatic test_lock();
`ifdef UART_TX_ARB_LOCK_EN
    int order [5] = '{3, 3, 3, 0, 1};
`else
    int order [5] = '{3, 0, 1, 3, 3};
`endif
    bit ok;
    do_reset();
    @(negedge i_Clock); #1;
    push_req(2, 8'h11, 1'b1);
    predict();
    wait_grants(1, ok);
    wait_idle(ok);
    clear_all();
    push_req(3, 8'h31, 1'b0);
    push_req(3, 8'h32, 1'b0);
    push_req(3, 8'h33, 1'b1);
    push_req(0, 8'h01, 1'b1);
    push_req(1, 8'h02, 1'b1);
    predict();
    wait_grants(5, ok);
    for (int i = 0; i < 5; i++) begin
      num_checks++;
      if (i >= got_idx_q.size() || got_idx_q[i] !== IDX_W'(order[i]) || got_idx_q[i] !== exp_idx_q[i] || got_byte_q[i] !== exp_byte_q[i]) begin
        num_errors++; $display("FAIL lock_order%0d: grant mismatch, required idx %0d", i, order[i]);
      end
    end
    wait_idle(ok);
    clear_all();
  endtask

  task automatic test_random();
    bit ok;
    int n, total;
    for (int round = 0; round < 4; round++) begin
      @(negedge i_Clock); #1;
      total = 0;
      for (int r = 0; r < NUM_REQ; r++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          push_req(r, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        total += n;
      end
      predict();
      wait_grants(total, ok);
      num_checks++;
      if (!ok) begin num_errors++; $display("FAIL rand_timeout: %0d grants, required %0d", got_idx_q.size(), total); end
      for (int i = 0; i < total && i < got_idx_q.size(); i++) begin
        num_checks++;
        if (got_idx_q[i] !== exp_idx_q[i] || got_byte_q[i] !== exp_byte_q[i]) begin
          num_errors++; $display("FAIL rand_r%0d_g%0d: idx %0d byte %h, required idx %0d byte %h",
                                 round, i, got_idx_q[i], got_byte_q[i], exp_idx_q[i], exp_byte_q[i]);
        end
      end
      wait_idle(ok);
      clear_all();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b;
    @(negedge i_Clock); #1;
    push_req(1, 8'h77, 1'b1);
    push_req(1, 8'h78, 1'b1);
    predict();
    wait_grants(1, ok);
    b = 0;
    while (!mdl_active && b < 50) begin @(negedge i_Clock); #1; b++; end
    repeat (5) @(negedge i_Clock);
    i_Rst_L = 1'b0;
    #1;
    num_checks += 2;
    if (o_TX_DV !== 0 || o_TX_Byte !== 0 || o_Req_Ready !== 0 || o_Grant_Idx !== 0 || o_Err !== 0) begin
      num_errors++; $display("FAIL midrst_outputs: dv=%b byte=%h ready=%b idx=%0d err=%b, required all 0",
                             o_TX_DV, o_TX_Byte, o_Req_Ready, o_Grant_Idx, o_Err);
    end
    if (o_Busy !== 1'b0) begin num_errors++; $display("FAIL midrst_busy: %b, required 0", o_Busy); end
    clear_all();
    repeat (2) @(negedge i_Clock);
    i_Rst_L = 1'b1;
    mdl_ptr = 0;
    #1;
    push_req(3, 8'hC3, 1'b1);
    push_req(2, 8'hC2, 1'b1);
    push_req(0, 8'hC0, 1'b1);
    predict();
    wait_grants(3, ok);
    num_checks += 2;
    if (!ok || got_idx_q[0] !== 2'd0) begin num_errors++; $display("FAIL midrst_first: first grant not requester 0"); end
    else if (got_idx_q[1] !== exp_idx_q[1] || got_idx_q[2] !== exp_idx_q[2] || got_byte_q[2] !== exp_byte_q[2]) begin
      num_errors++; $display("FAIL midrst_order: %0d,%0d required %0d,%0d", got_idx_q[1], got_idx_q[2], exp_idx_q[1], exp_idx_q[2]);
    end
    if (err_cyc_q.size() != 0) begin num_errors++; $display("FAIL midrst_err: %0d err pulses, required 0", err_cyc_q.size()); end
    wait_idle(ok);
    clear_all();
  endtask

  initial begin
    i_Rst_L    = 1'b0;
    frc_active = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    mdl_ptr    = 0;
    for (int r = 0; r < NUM_REQ; r++) begin rq_head[r] = 0; rq_tail[r] = 0; end
    @(negedge i_Clock);
    test_reset();
    test_single();
    test_round_robin();
    test_active_hold();
    test_timeout();
    test_lock();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between up to eight byte-producing requesters. Requests are granted round-robin, one byte at a time. The block drives the transmitter's data-valid/byte inputs and tracks its active/done outputs so that exactly one byte is in flight. It sits directly in front of the transmitter; requesters never touch it directly.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ACK_TIMEOUT, 4, cycles allowed after launch for i_TX_Active to rise

Ports:
- i_Clock  in  1  system clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Req_Valid  in  NUM_REQ  per-requester byte pending; held with data until acknowledged
- i_Req_Data  in  8*NUM_REQ  requester r byte at [8r+7:8r]
- i_Req_Last  in  NUM_REQ  byte is last of packet (used only with lock feature)
- o_Req_Ready  out  NUM_REQ  one-hot, one-cycle acknowledge: byte captured
- o_TX_DV  out  1  one-cycle launch strobe to transmitter
- o_TX_Byte  out  8  byte to transmitter, stable from launch until next launch
- i_TX_Active  in  1  transmitter busy
- i_TX_Done  in  1  transmitter one-cycle completion pulse
- o_Grant_Idx  out  clog2(NUM_REQ)  index of last granted requester
- o_Busy  out  1  high in any state other than ARB
- o_Err  out  1  one-cycle pulse on launch timeout

## Operation
States: ARB, LAUNCH, WAIT_ACT, WAIT_DONE.
- ARB: if any i_Req_Valid is set and i_TX_Active=0, pick winner w and go to LAUNCH. At that same edge:
  - capture i_Req_Data[w] into o_TX_Byte
  - set o_TX_DV=1, o_Req_Ready[w]=1, o_Grant_Idx=w
  - set pointer = (w+1) mod NUM_REQ
- Otherwise stay in ARB.
- Round-robin: search starts at the pointer and wraps upward. The pointer resets to 0.
- LAUNCH (1 cycle): o_TX_DV and o_Req_Ready return to 0. Go to WAIT_ACT.
- WAIT_ACT: if i_TX_Active=1, go to WAIT_DONE. Otherwise increment the timeout counter. After ACK_TIMEOUT cycles without Active: pulse o_Err, clear the lock, return to ARB. The byte is dropped and not retried.
- WAIT_DONE: on i_TX_Done=1, go to ARB.
  - i_TX_Done arriving in WAIT_ACT (short transfer) is treated as Active-then-Done and goes to ARB.
- i_Req_Valid is sampled only in ARB. A requester drops or advances Valid/Data on the cycle its Ready is high.
- Valid deasserted before being granted: request withdrawn, no error.
- Reset mid-transfer: all state is cleared asynchronously. No Ready, Done or Err is issued for the aborted byte.

## Timing
- Reset values: o_TX_DV=0, o_TX_Byte=0, o_Req_Ready=0, o_Grant_Idx=0, o_Busy=0, o_Err=0. State=ARB, pointer=0, lock clear.
- Valid sampled at edge k leads to o_TX_DV and o_Req_Ready high during cycle k..k+1 (one cycle). The transmitter sees DV at edge k+1 and raises Active after that.
- i_TX_Done high at edge d: state is ARB after d. The next o_TX_DV rises at edge d+1 at the earliest. Inter-byte overhead is 2 clocks beyond the transmitter's frame.
- Timeout counter width is clog2(ACK_TIMEOUT+1). It clears on entering WAIT_ACT.

## Configuration
- UART_TX_ARB_LOCK_EN defined: packet lock.
  - If a granted byte has i_Req_Last[w]=0, the lock is set to w. ARB then considers only requester w.
  - The pointer is not advanced while locked.
  - The lock clears when a byte with Last=1 is granted, or on o_Err.
- UART_TX_ARB_LOCK_EN undefined: i_Req_Last is ignored and every byte is arbitrated independently.

## Structure
- Package uart_pkg holds:
  - the arbiter state encoding: ARB=2'b00, LAUNCH=2'b01, WAIT_ACT=2'b10, WAIT_DONE=2'b11
  - the ACK_TIMEOUT default
  - the NUM_REQ maximum of 8
- Sub-module uart_rr_picker: combinational round-robin priority picker. Inputs are the request vector and the pointer. Outputs are the one-hot grant, the index, and an any-request flag.

## Test plan
- NUM_REQ=4, CLKS_PER_BIT=4 transmitter model, only requester 2 valid with 8'hA5 -> one Ready[2] pulse, o_TX_Byte=8'hA5, Grant_Idx=2, serial frame 0,1,0,1,0,0,1,0,1,1.
- All four valid, each holding Valid for 2 bytes -> grant order 0,1,2,3,0,1,2,3. Never two Ready bits in one cycle.
- Requester 1 Valid while i_TX_Active=1 -> no o_TX_DV until the cycle after i_TX_Done. Then DV exactly one cycle.
- Transmitter model ignores DV -> o_Err pulses 4 cycles after WAIT_ACT entry, state returns to ARB, next request launches normally.
- With UART_TX_ARB_LOCK_EN: requester 3 sends 3 bytes with Last=0,0,1 while 0 and 1 are valid -> 3,3,3 then 0. Without the macro -> 3,0,1,3.
- Assert i_Rst_L low during WAIT_DONE -> all outputs 0 immediately, pointer 0. After release, requester 0 is granted first.
